// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI master: one DATA_W-bit frame per accepted request,
// with programmable sck divider and chip-select setup, hold and idle timing.
module spi_master #(
  parameter int DATA_W   = 32,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int BIT_RAW = $clog2(DATA_W + 1);
  localparam int BIT_W   = (BIT_RAW < 6) ? 6 : BIT_RAW;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  // tx_shift holds the bits still to be sent, already advanced past the one
  // currently on mosi, so the next bit is always at the MSB.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_ready && tx_valid) begin
            state    <= SETUP;
            cnt      <= '0;
            cs_n     <= 1'b0;
            mosi     <= tx_data[DATA_W-1];
            tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= XFER;
            cnt     <= '0;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!sck) begin
              sck      <= 1'b1;
              rx_shift <= {rx_shift[DATA_W-2:0], miso};
              bit_cnt  <= bit_cnt + 1'b1;
            end else begin
              sck <= 1'b0;
              // The last falling edge leaves mosi on the final bit.
              if (bit_cnt == BIT_LAST) begin
                state <= HOLD;
              end else begin
                mosi     <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state    <= GAP;
            cnt      <= '0;
            cs_n     <= 1'b1;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          // tx_ready is raised by IDLE one cycle later, as after reset.
          if (cnt == IDLE_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          sck   <= 1'b0;
          cs_n  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1)
// checked against a frame-level model of bits, edge counts and cycle counts.
module tb_spi_master;

  localparam int W       = 32;
  localparam int A_DIV   = 2;
  localparam int A_SETUP = 1;
  localparam int A_HOLD  = 1;
  localparam int B_DIV   = 1;
  localparam int B_SETUP = 2;
  localparam int B_HOLD  = 2;
  localparam int IDLE_N  = 4;

  logic         CLK = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         sel = 1'b0;
  logic         loop = 1'b0;
  logic         drv_miso = 1'b0;

  logic         tx_ready_a, rx_valid_a, busy_a, sck_a, cs_n_a, mosi_a, miso_a;
  logic         tx_ready_b, rx_valid_b, busy_b, sck_b, cs_n_b, mosi_b, miso_b;
  logic [W-1:0] rx_data_a, rx_data_b;
  logic         tx_valid_a, tx_valid_b;

  logic         m_tx_ready, m_rx_valid, m_busy, m_sck, m_cs_n, m_mosi;
  logic [W-1:0] m_rx_data;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  assign tx_valid_a = tx_valid & ~sel;
  assign tx_valid_b = tx_valid & sel;
  assign miso_a = loop ? mosi_a : drv_miso;
  assign miso_b = loop ? mosi_b : drv_miso;

  assign m_tx_ready = sel ? tx_ready_b : tx_ready_a;
  assign m_rx_valid = sel ? rx_valid_b : rx_valid_a;
  assign m_busy     = sel ? busy_b     : busy_a;
  assign m_sck      = sel ? sck_b      : sck_a;
  assign m_cs_n     = sel ? cs_n_b     : cs_n_a;
  assign m_mosi     = sel ? mosi_b     : mosi_a;
  assign m_rx_data  = sel ? rx_data_b  : rx_data_a;

  spi_master #(.DATA_W(W), .CLK_DIV(A_DIV), .CS_SETUP(A_SETUP), .CS_HOLD(A_HOLD), .CS_IDLE(IDLE_N)) dut_a (
    .CLK(CLK), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a), .sck(sck_a), .cs_n(cs_n_a),
    .mosi(mosi_a), .miso(miso_a)
  );

  spi_master #(.DATA_W(W), .CLK_DIV(B_DIV), .CS_SETUP(B_SETUP), .CS_HOLD(B_HOLD), .CS_IDLE(IDLE_N)) dut_b (
    .CLK(CLK), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b), .sck(sck_b), .cs_n(cs_n_b),
    .mosi(mosi_b), .miso(miso_b)
  );

  typedef struct {
    logic [W-1:0] txw;
    logic [W-1:0] misow;
    bit           lp;
    bit           sel;
  } vec_t;

  vec_t vecs[9];

  logic [W-1:0] cap_mosi, cap_rx;
  int           cap_low, cap_rises, cap_rxv_low, cap_rxv_end, cap_viol;
  bit           cap_to, cap_aborted;
  int           pw_low, pw_rxv;

  // Expected chip-select low time for the selected instance.
  function automatic int expLow(input bit s);
    if (s) return B_SETUP + 2 * B_DIV * W + B_HOLD;
    return A_SETUP + 2 * A_DIV * W + A_HOLD;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Presents a request and returns #1 after the accepting clock edge.
  task automatic applyStimulus(input logic [W-1:0] txw, input bit keep_valid);
    int budget;
    @(negedge CLK);
    tx_data  = txw;
    tx_valid = 1'b1;
    budget   = 0;
    while (m_tx_ready !== 1'b1 && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    if (budget >= 200) checkOutput("accept_timeout", 32'd1, 32'd0);
    @(posedge CLK);
    #1;
    if (!keep_valid) begin
      tx_valid = 1'b0;
      tx_data  = $urandom;
    end
  endtask

  // Observes one frame starting just after acceptance; plays the slave side
  // by shifting misow out MSB first, advancing after each sck falling edge.
  task automatic captureFrame(input logic [W-1:0] misow, input int poke_at, input int abort_at);
    int  budget;
    int  idx;
    bit  prev;
    bit  poked;
    bit  done;
    cap_mosi = '0; cap_rx = '0; cap_low = 0; cap_rises = 0;
    cap_rxv_low = 0; cap_rxv_end = 0; cap_viol = 0; cap_to = 0; cap_aborted = 0;
    prev = 1'b0; poked = 1'b0; done = 1'b0; idx = W - 1; budget = 0;
    while (!done && budget < 2000) begin
      @(negedge CLK);
      budget++;
      if (poked && tx_valid) tx_valid = 1'b0;
      if (m_cs_n === 1'b0) begin
        if (cap_low == 0) drv_miso = misow[W-1];
        cap_low++;
        if (m_tx_ready !== 1'b0 || m_busy !== 1'b1) cap_viol++;
        if (m_rx_valid !== 1'b0) cap_rxv_low++;
        if (m_sck === 1'b1 && !prev) begin
          cap_mosi = {cap_mosi[W-2:0], m_mosi};
          cap_rises++;
          if (cap_rises == poke_at && !poked) begin
            tx_data  = 32'hDEAD_BEEF;
            tx_valid = 1'b1;
            poked    = 1'b1;
          end
          if (cap_rises == abort_at) begin
            rst_n = 1'b0;
            #1;
            checkOutput("abort_cs_n", 32'(m_cs_n), 32'd1);
            checkOutput("abort_sck", 32'(m_sck), 32'd0);
            cap_aborted = 1'b1;
            done = 1'b1;
          end
        end
        if (m_sck === 1'b0 && prev && idx > 0) begin
          idx--;
          drv_miso = misow[idx];
        end
        prev = m_sck;
      end else if (cap_low > 0) begin
        cap_rxv_end = int'(m_rx_valid);
        cap_rx      = m_rx_data;
        done        = 1'b1;
      end
    end
    if (!done) cap_to = 1'b1;
  endtask

  task automatic postWatch(input int n);
    pw_low = 0;
    pw_rxv = 0;
    repeat (n) begin
      @(negedge CLK);
      if (m_cs_n === 1'b0) pw_low++;
      if (m_rx_valid !== 1'b0) pw_rxv++;
    end
  endtask

  task automatic checkFrame(input string tag, input logic [W-1:0] txw, input logic [W-1:0] exp_rx);
    checkOutput({tag, "_timeout"}, 32'(cap_to), 32'd0);
    checkOutput({tag, "_mosi"}, cap_mosi, txw);
    checkOutput({tag, "_rx_data"}, cap_rx, exp_rx);
    checkOutput({tag, "_cs_low"}, 32'(cap_low), 32'(expLow(sel)));
    checkOutput({tag, "_rises"}, 32'(cap_rises), 32'(W));
    checkOutput({tag, "_rxv_end"}, 32'(cap_rxv_end), 32'd1);
    checkOutput({tag, "_rxv_early"}, 32'(cap_rxv_low), 32'd0);
    checkOutput({tag, "_ready_busy"}, 32'(cap_viol), 32'd0);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    sel  = v.sel;
    loop = v.lp;
    applyStimulus(v.txw, 1'b0);
    captureFrame(v.misow, 0, 0);
    checkFrame(tag, v.txw, v.lp ? v.txw : v.misow);
    postWatch(3);
    checkOutput({tag, "_rxv_single"}, 32'(pw_rxv), 32'd0);
  endtask

  initial begin
    logic [W-1:0] w;
    int gap;
    int budget;

    vecs[0] = '{32'hA5A5_1234, $urandom, 1'b0, 1'b0};
    vecs[1] = '{32'h0FA0_05DC, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0, 1'b1, 1'b0};
    vecs[4] = '{$urandom, $urandom, 1'b0, 1'b0};
    vecs[5] = '{$urandom, $urandom, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0001, $urandom, 1'b0, 1'b1};
    vecs[7] = '{$urandom, $urandom, 1'b0, 1'b1};
    vecs[8] = '{$urandom, 32'h0, 1'b1, 1'b1};

    // Reset values, then tx_ready rising one edge after release.
    #12;
    checkOutput("rst_cs_n", 32'(cs_n_a), 32'd1);
    checkOutput("rst_sck", 32'(sck_a), 32'd0);
    checkOutput("rst_mosi", 32'(mosi_a), 32'd0);
    checkOutput("rst_tx_ready", 32'(tx_ready_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid_a), 32'd0);
    checkOutput("rst_rx_data", rx_data_a, 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("release_tx_ready", 32'(tx_ready_a), 32'd1);

    for (int i = 0; i < 9; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with tx_valid held: each word goes out once, in order.
    sel  = 1'b0;
    loop = 1'b1;
    applyStimulus(32'h1111_2222, 1'b1);
    tx_data = 32'h3333_4444;
    captureFrame(32'h0, 0, 0);
    checkFrame("b2b_first", 32'h1111_2222, 32'h1111_2222);
    gap = 1;
    budget = 0;
    while (budget < 100) begin
      @(posedge CLK);
      #1;
      budget++;
      if (m_cs_n === 1'b0) break;
      gap++;
    end
    tx_valid = 1'b0;
    checkOutput("b2b_gap", 32'(gap), 32'(IDLE_N + 2));
    captureFrame(32'h0, 0, 0);
    checkFrame("b2b_second", 32'h3333_4444, 32'h3333_4444);
    postWatch(20);
    checkOutput("b2b_no_third", 32'(pw_low), 32'd0);

    // A request during a frame is dropped, not queued.
    loop = 1'b0;
    w = $urandom;
    vecs[0].misow = $urandom;
    applyStimulus(w, 1'b0);
    captureFrame(vecs[0].misow, 8, 0);
    checkFrame("busy_rej", w, vecs[0].misow);
    postWatch(20);
    checkOutput("busy_rej_no_frame", 32'(pw_low), 32'd0);

    // Reset after ten sck rising edges abandons the frame silently.
    applyStimulus($urandom, 1'b0);
    captureFrame($urandom, 0, 10);
    checkOutput("abort_seen", 32'(cap_aborted), 32'd1);
    postWatch(3);
    checkOutput("abort_rxv", 32'(pw_rxv), 32'd0);
    checkOutput("abort_cs_low", 32'(pw_low), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("abort_ready_low", 32'(m_tx_ready), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("abort_ready_rise", 32'(m_tx_ready), 32'd1);
    vecs[0] = '{32'h1234_5678, $urandom, 1'b0, 1'b0};
    runVector(vecs[0], "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- System-clock-driven SPI master (mode 0, MSB first) that sends one DATA_W-bit frame per accepted request on sck/cs_n/mosi.
- It is the controller-side counterpart of the 32-bit servo SPI slave: high 16 bits carry servo 1, low 16 bits carry servo 2.
- It samples miso while shifting, so the received word is returned as rx_data.
- Used in loopback benches and on boards where the FPGA drives a downstream servo controller.

Parameters:
- DATA_W, 32, frame length in bits; must be at least 2.
- CLK_DIV, 4, CLK cycles per sck half-period; must be at least 1.
- CS_SETUP, 2, CLK cycles from cs_n falling to the first sck rising edge phase start; must be at least 1.
- CS_HOLD, 2, CLK cycles from the final sck falling edge to cs_n rising; must be at least 1.
- CS_IDLE, 4, minimum CLK cycles cs_n stays high between frames; must be at least 1.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_W  word to send, MSB first.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  block idle and able to accept a request.
- rx_data  output  DATA_W  word sampled from miso during the last frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high from acceptance until the end of the CS_IDLE gap.
- sck  output  1  SPI clock; idles low.
- cs_n  output  1  chip select, active low.
- mosi  output  1  master out.
- miso  input  1  master in.

Behaviour:
- All outputs are registered.
- Reset values: sck=0, cs_n=1, mosi=0, tx_ready=0, busy=0, rx_valid=0, rx_data=0.
- While rst_n=0, cs_n goes high immediately (asynchronous). This guarantees the slave aborts any partial frame.
- State machine states: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE: tx_ready=1, busy=0, cs_n=1, sck=0.
  - A handshake occurs at a CLK edge where tx_valid=1 and tx_ready=1.
  - On the handshake, latch tx_data into the shift register and go to SETUP.
  - Next cycle: cs_n=0, mosi=tx_data[DATA_W-1], tx_ready=0, busy=1.
- SETUP: lasts CS_SETUP cycles with sck=0, then go to XFER.
- XFER: each bit is CLK_DIV cycles with sck low, then CLK_DIV cycles with sck high.
  - At the CLK edge that drives sck 0->1, sample miso into the receive shift register (LSB in, shift left).
  - At the edge that drives sck 1->0, present the next bit on mosi. mosi is not updated after the final bit.
  - Exactly DATA_W rising sck edges per frame. XFER lasts 2*CLK_DIV*DATA_W cycles and ends with sck=0.
  - A 6-bit-or-wider bit counter plus a half-period counter are required. The bit counter must count 0..DATA_W without overflow.
- HOLD: lasts CS_HOLD cycles with sck=0 and cs_n=0. On exit, cs_n=1, rx_data is updated with the received word, and rx_valid=1 for exactly one cycle.
- GAP: lasts CS_IDLE cycles with cs_n=1 (the cycle cs_n rises counts as the first), then return to IDLE with tx_ready=1.
- Frame length: cs_n low for exactly CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD cycles.
- Minimum spacing from one acceptance to the next: that value + CS_IDLE + 2 cycles.
- tx_valid while tx_ready=0 is ignored; no queueing. tx_data may change freely after the handshake.
- A back-to-back request held high is accepted on the first IDLE cycle.
- Reset mid-frame: the frame is abandoned, no rx_valid is produced, and after release the block enters IDLE. tx_ready rises on the first CLK edge after rst_n deasserts.
- CLK_DIV=1: sck toggles every CLK cycle, with one CLK per phase.
- miso is treated as synchronous; the board keeps the sck rate well below CLK.

Test Plan:
1. Basic frame: CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, send 0xA5A5_1234 -> 32 sck rising edges, mosi at each rise equals 0xA5A5_1234 MSB first, cs_n low for exactly 130 CLK cycles, one rx_valid pulse.
2. Loopback: miso tied to mosi, send 0x0FA0_05DC -> rx_data = 0x0FA0_05DC on the rx_valid cycle. Repeat with 0xFFFF_FFFF and 0x0000_0000.
3. Back-to-back with the servo slave attached: tx_valid held high with words 0x1111_2222 then 0x3333_4444 -> slave data_out takes each value in order, with cs_n high at least CS_IDLE cycles between frames. The slave's rx_valid asserts once per frame.
4. Busy rejection: pulse tx_valid with 0xDEAD_BEEF mid-frame -> ignored; only the original word is transmitted; tx_ready=0 throughout.
5. Reset mid-frame: assert rst_n=0 after 10 sck rising edges -> cs_n=1 and sck=0 in the same cycle, no rx_valid; after release a new frame of 0x1234_5678 completes correctly.
6. CLK_DIV=1 edge case: send 0x8000_0001 -> sck period is 2 CLK cycles, the first and last mosi bits are 1 and all others 0, and cs_n low time is CS_SETUP+64+CS_HOLD cycles.
